pwm_meter: RTL and testbench

- Downstream consumer of the PWM generator output.
- Measures high time and period of a PWM waveform, in clk cycles, on every full cycle.
- Results go out through a one-entry valid/ready buffer.
- Flags stuck-at levels (0 %/100 % duty, or generator stopped) via timeout.
- The input may be asynchronous (pin loopback) or on-chip; it is always synchronised internally.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_meter_sync_edge.sv | 38 +++
 rtl/pwm_meter.sv | 164 ++++++++++++++++
 tb/tb_pwm_meter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM meter
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meter_state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int CNT_W_DEFAULT       = 24;

    // All-ones value of a counter of the given width; the saturation and timeout point.
    function automatic logic [63:0] cnt_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/pwm_meter_sync_edge.sv
// rtl/pwm_meter_sync_edge.sv - input synchroniser with rise/fall edge detection
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              level_d;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    // One-cycle delayed copy of the synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/pwm_meter.sv
// rtl/pwm_meter.sv - measures PWM high time and period with stuck detection
module pwm_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             clear,
    output logic [CNT_W-1:0] res_high,
    output logic [CNT_W-1:0] res_period,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overrun,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    logic             rise;
    logic             fall;
    meter_state_t     state_q;
    meter_state_t     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] high_cap_q;
    logic [CNT_W-1:0] high_cap_d;
    logic             qual_edge;
    logic             meas;
    logic             timeout;
    logic             restart;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwm_in),
        .level (s),
        .rise  (rise),
        .fall  (fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter update, capture and measurement/timeout strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        high_cap_d = high_cap_q;
        qual_edge  = 1'b0;
        meas       = 1'b0;
        timeout    = 1'b0;
        restart    = 1'b0;

        if (rise) begin
            cnt_d = CNT_ONE;
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    qual_edge = 1'b1;
                    restart   = 1'b1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    qual_edge  = 1'b1;
                    high_cap_d = cnt_q;
                    state_d    = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    qual_edge = 1'b1;
                    meas      = 1'b1;
                    restart   = 1'b1;
                    state_d   = HIGH;
                end
            end
            default: state_d = IDLE;
        endcase

        // A saturated counter without the edge this state is waiting for means
        // the waveform has stopped; fall back to waiting for a fresh rise.
        if ((cnt_q == CNT_MAX) && !qual_edge) begin
            timeout = 1'b1;
            state_d = IDLE;
        end

        // Soft clear discards any edge seen in the same cycle.
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            meas    = 1'b0;
            timeout = 1'b0;
            restart = 1'b0;
        end
    end

    // Cycle counter and captured high time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            high_cap_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            high_cap_q <= high_cap_d;
        end
    end

    // One-entry result buffer, overrun and stuck flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_high    <= '0;
            res_period  <= '0;
            res_valid   <= 1'b0;
            overrun     <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else if (clear) begin
            res_valid   <= 1'b0;
            overrun     <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            if (meas) begin
                if (!res_valid || res_ready) begin
                    res_high   <= high_cap_q;
                    res_period <= cnt_q;
                    res_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            // Level is latched only when the flag first sets, so later edges
            // seen while idling do not overwrite the reported stuck level.
            if (restart) begin
                stuck <= 1'b0;
            end else if (timeout && !stuck) begin
                stuck       <= 1'b1;
                stuck_level <= s;
            end
        end
    end

endmodule

// File: tb/tb_pwm_meter.sv
// tb/tb_pwm_meter.sv - randomized self-checking bench for pwm_meter
module tb_pwm_meter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pwm_in = 1'b0;
    logic         clear = 1'b0;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_high;
    logic [W-1:0] res_period;
    logic         res_valid;
    logic         overrun;
    logic         stuck;
    logic         stuck_level;

    int total = 0;
    int bad = 0;
    int valid_cycles = 0;
    logic [2*W-1:0] got[$];

    pwm_meter #(
        .CNT_W       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .clear       (clear),
        .res_high    (res_high),
        .res_period  (res_period),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .overrun     (overrun),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    // Record every accepted result and count cycles with a result on offer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid) valid_cycles++;
            if (res_valid && res_ready) got.push_back({res_high, res_period});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pwm_in = 1'b0; res_ready = 1'b1;
        repeat (3) tick();
        total++; if ({res_valid, overrun, stuck, stuck_level} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b expected 0000", {res_valid, overrun, stuck, stuck_level}); end
        total++; if ({res_high, res_period} !== '0) begin bad++; $display("FAIL reset_results: got %0d/%0d expected 0/0", res_high, res_period); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_clean();
        int base;
        int v0;
        base = got.size();
        v0 = valid_cycles;
        res_ready = 1'b1;
        hold(1'b0, 4);
        for (int p = 0; p < 6; p++) begin
            hold(1'b1, 3);
            hold(1'b0, 5);
        end
        hold(1'b1, 5);
        total++; if (got.size() - base !== 6) begin bad++; $display("FAIL clean_count: got %0d expected 6", got.size() - base); end
        for (int i = 0; i < 6 && base + i < got.size(); i++) begin
            total++; if (got[base+i] !== {8'd3, 8'd8}) begin bad++; $display("FAIL clean_res%0d: got %0d/%0d expected 3/8", i, got[base+i][15:8], got[base+i][7:0]); end
        end
        total++; if (valid_cycles - v0 !== 6) begin bad++; $display("FAIL clean_valid_pulses: got %0d expected 6", valid_cycles - v0); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clean_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_backpressure();
        int base;
        hold(1'b0, 10);
        res_ready = 1'b0;
        pulse_clear();
        hold(1'b1, 2); hold(1'b0, 5);
        hold(1'b1, 3); hold(1'b0, 5);
        hold(1'b1, 4); hold(1'b0, 4);
        hold(1'b1, 5); hold(1'b0, 3);
        hold(1'b0, 5);
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held: got %b expected 1", res_valid); end
        total++; if ({res_high, res_period} !== {8'd2, 8'd7}) begin bad++; $display("FAIL bp_first_held: got %0d/%0d expected 2/7", res_high, res_period); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
        base = got.size();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drain: got %b expected 0", res_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_sticky: got %b expected 1", overrun); end
        total++; if (got.size() - base !== 1 || got[got.size()-1] !== {8'd2, 8'd7}) begin bad++; $display("FAIL bp_accepted: got count %0d expected one 2/7", got.size() - base); end
    endtask

    task automatic test_clear();
        int base;
        logic [2*W-1:0] exp[$];
        res_ready = 1'b0;
        hold(1'b1, 3);
        hold(1'b0, 4);
        total++; if ({res_valid, overrun} !== 2'b11) begin bad++; $display("FAIL clr_pre: got %b expected 11", {res_valid, overrun}); end
        pulse_clear();
        total++; if ({res_valid, overrun, stuck, stuck_level} !== 4'b0) begin bad++; $display("FAIL clr_flags: got %b expected 0000", {res_valid, overrun, stuck, stuck_level}); end
        res_ready = 1'b1;
        base = got.size();
        hold(1'b0, 3);
        hold(1'b1, 2); hold(1'b0, 6);
        hold(1'b1, 5); hold(1'b0, 2);
        hold(1'b1, 5);
        exp.push_back({8'd2, 8'd8});
        exp.push_back({8'd5, 8'd7});
        total++; if (got.size() - base !== exp.size()) begin bad++; $display("FAIL clr_count: got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
            total++; if (got[base+i] !== exp[i]) begin bad++; $display("FAIL clr_res%0d: got %0d/%0d expected %0d/%0d", i, got[base+i][15:8], got[base+i][7:0], exp[i][15:8], exp[i][7:0]); end
        end
    endtask

    task automatic test_random();
        int base;
        int h;
        int l;
        logic [2*W-1:0] exp[$];
        res_ready = 1'b1;
        hold(1'b0, 6);
        pulse_clear();
        base = got.size();
        for (int p = 0; p < 20; p++) begin
            h = $urandom_range(1, 12);
            l = $urandom_range(1, 12);
            exp.push_back({8'(h), 8'(h + l)});
            hold(1'b1, h);
            hold(1'b0, l);
        end
        hold(1'b1, 5);
        total++; if (got.size() - base !== exp.size()) begin bad++; $display("FAIL rnd_count: got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
            total++; if (got[base+i] !== exp[i]) begin bad++; $display("FAIL rnd_res%0d: got %0d/%0d expected %0d/%0d", i, got[base+i][15:8], got[base+i][7:0], exp[i][15:8], exp[i][7:0]); end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rnd_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_stuck_high();
        int base;
        res_ready = 1'b1;
        hold(1'b0, 6);
        pulse_clear();
        tick();
        pwm_in = 1'b1;
        repeat (257) tick();
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL sh_early: got %b expected 0", stuck); end
        tick();
        total++; if ({stuck, stuck_level} !== 2'b11) begin bad++; $display("FAIL sh_set: got %b expected 11", {stuck, stuck_level}); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL sh_valid: got %b expected 0", res_valid); end
        base = got.size();
        hold(1'b0, 4);
        total++; if ({stuck, stuck_level} !== 2'b11) begin bad++; $display("FAIL sh_level_kept: got %b expected 11", {stuck, stuck_level}); end
        hold(1'b1, 2);
        total++; if (stuck !== 1'b1) begin bad++; $display("FAIL sh_before_rise: got %b expected 1", stuck); end
        tick();
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL sh_cleared: got %b expected 0", stuck); end
        tick();
        hold(1'b0, 4);
        hold(1'b1, 5);
        total++; if (got.size() - base !== 1 || got[got.size()-1] !== {8'd4, 8'd8}) begin bad++; $display("FAIL sh_result: got count %0d expected one 4/8", got.size() - base); end
    endtask

    task automatic test_async_reset();
        int base;
        logic [2*W-1:0] exp[$];
        res_ready = 1'b0;
        hold(1'b0, 4);
        pulse_clear();
        hold(1'b1, 3); hold(1'b0, 5);
        hold(1'b1, 3); hold(1'b0, 5);
        hold(1'b1, 5);
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid: got %b expected 1", res_valid); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if ({res_valid, overrun, stuck, stuck_level} !== 4'b0 || {res_high, res_period} !== '0) begin bad++; $display("FAIL ar_immediate: got flags %b results %0d/%0d expected all 0", {res_valid, overrun, stuck, stuck_level}, res_high, res_period); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        base = got.size();
        // Synchroniser restarts at 0, so the still-high input looks like a rise at release.
        hold(1'b1, 3); hold(1'b0, 5);
        hold(1'b1, 4); hold(1'b0, 4);
        hold(1'b1, 5);
        exp.push_back({8'd3, 8'd8});
        exp.push_back({8'd4, 8'd8});
        total++; if (got.size() - base !== exp.size()) begin bad++; $display("FAIL ar_count: got %0d expected %0d", got.size() - base, exp.size()); end
        for (int i = 0; i < exp.size() && base + i < got.size(); i++) begin
            total++; if (got[base+i] !== exp[i]) begin bad++; $display("FAIL ar_res%0d: got %0d/%0d expected %0d/%0d", i, got[base+i][15:8], got[base+i][7:0], exp[i][15:8], exp[i][7:0]); end
        end
    endtask

    task automatic test_stuck_low();
        int base;
        pwm_in = 1'b0;
        res_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base = got.size();
        repeat (250) tick();
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL sl_early: got %b expected 0", stuck); end
        repeat (10) tick();
        total++; if ({stuck, stuck_level} !== 2'b10) begin bad++; $display("FAIL sl_set: got %b expected 10", {stuck, stuck_level}); end
        total++; if (res_valid !== 1'b0 || got.size() != base) begin bad++; $display("FAIL sl_no_result: got valid %b count %0d expected 0 0", res_valid, got.size() - base); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_backpressure();
        test_clear();
        test_random();
        test_stuck_high();
        test_async_reset();
        test_stuck_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
